// File: rtl/fft_frame_loader.sv
// fft_frame_loader: pulls FRAME_LEN samples per frame from a fixed-latency
// sample source and streams them to an FFT core load port as real-only
// complex data, with start/end-of-frame markers and a small skid FIFO.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_start          one-cycle pulse starting a frame (ignored while busy)
//   o_src_req        registered read/advance request to the source
//   i_src_data       source sample, valid SRC_LAT cycles after o_src_req
//   o_xn_re/o_xn_im  sample to the FFT core (imaginary part always 0)
//   o_xn_valid       o_xn_* carries a sample; handshake with i_xn_ready
//   o_xn_sof/o_xn_eof  marks sample index 0 / FRAME_LEN-1
//   o_busy           frame in progress
//   o_frame_done     one-cycle pulse after the last handshake
//   o_frame_cnt      completed frames, wrapping
module fft_frame_loader #(
    parameter int FRAME_LEN  = 1024,
    parameter int DW         = 16,
    parameter int SRC_LAT    = 1,
    parameter int OFFSET_BIN = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic          o_src_req,
    input  logic [DW-1:0] i_src_data,
    output logic [DW-1:0] o_xn_re,
    output logic [DW-1:0] o_xn_im,
    output logic          o_xn_valid,
    output logic          o_xn_sof,
    output logic          o_xn_eof,
    input  logic          i_xn_ready,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic [15:0]   o_frame_cnt
);
    localparam int DEPTH = SRC_LAT + 2;
    localparam int IW    = $clog2(FRAME_LEN);
    localparam int CW    = IW + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int OW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_src_req;
    logic [SRC_LAT-1:0] r_pipe;
    logic [CW-1:0]      r_req_cnt;
    logic [IW-1:0]      r_out_idx;
    logic [DW-1:0]      r_mem [DEPTH];
    logic [PW-1:0]      r_rd_ptr, r_wr_ptr;
    logic [OW-1:0]      r_count;
    logic [15:0]        r_frame_cnt;
    logic               w_push, w_pop, w_eof_hs, w_room, w_req_nxt;
    logic [DW-1:0]      w_head;

    assign w_push   = r_pipe[SRC_LAT-1];
    assign w_pop    = o_xn_valid & i_xn_ready;
    assign w_eof_hs = o_xn_eof & i_xn_ready;
    assign w_head   = r_mem[r_rd_ptr];

    // A new request is only issued if the FIFO can hold it together with
    // everything already requested, counting this cycle's pop as freed space.
    assign w_room = (int'(r_count) + int'(r_src_req) + $countones(r_pipe) + 1)
                    <= (DEPTH + int'(w_pop));

    assign w_req_nxt = ((r_state == IDLE && i_start) || r_state == RUN)
                       && r_req_cnt < CW'(FRAME_LEN) && w_room;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  w_state_nxt = i_start ? RUN : IDLE;
            RUN:   w_state_nxt = (r_req_cnt == CW'(FRAME_LEN)) ? DRAIN : RUN;
            DRAIN: w_state_nxt = w_eof_hs ? DONE : DRAIN;
            DONE:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_src_req   <= 1'b0;
            r_pipe      <= '0;
            r_req_cnt   <= '0;
            r_out_idx   <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_src_req <= w_req_nxt;
            r_pipe    <= SRC_LAT'({r_pipe, r_src_req});
            r_req_cnt <= (r_state == DONE) ? '0 : r_req_cnt + CW'(w_req_nxt);
            r_count   <= r_count + OW'(w_push) - OW'(w_pop);
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr  <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                r_out_idx <= r_out_idx + 1'b1;
            end
            if (r_state == DONE)
                r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_src_data;
    end

    // Offset-binary to two's complement is just an MSB flip; output is
    // forced to 0 while empty so nothing stale leaks out after reset.
    assign o_xn_re      = o_xn_valid ? (w_head ^ {(OFFSET_BIN != 0), {(DW-1){1'b0}}}) : '0;
    assign o_xn_im      = '0;
    assign o_xn_valid   = r_count != '0;
    assign o_xn_sof     = o_xn_valid & (r_out_idx == '0);
    assign o_xn_eof     = o_xn_valid & (r_out_idx == IW'(FRAME_LEN - 1));
    assign o_src_req    = r_src_req;
    assign o_busy       = r_state != IDLE;
    assign o_frame_done = r_state == DONE;
    assign o_frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: bench for fft_frame_loader; a queue-based source and
// FIFO model predicts every output sample, marker and frame count.
module tb_fft_frame_loader;
    localparam int FL    = 1024;
    localparam int DW    = 16;
    localparam int SL    = 1;
    localparam int DEPTH = SL + 2;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, xn_ready = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_req, xn_valid, xn_sof, xn_eof, busy, frame_done;
    logic [DW-1:0] xn_re, xn_im;
    logic [15:0]   frame_cnt;
    logic          b_src_req, b_valid, b_sof, b_eof, b_busy, b_done;
    logic [DW-1:0] b_re, b_im;
    logic [15:0]   b_cnt;

    int checks = 0, errors = 0;
    logic          rq[$];
    logic [DW-1:0] expq[$];
    int addr = 0, hs_idx = 0, hs_cnt = 0, req_cnt = 0, done_cnt = 0, mode = 0;
    bit chk_en = 0, tab = 0;
    logic [DW-1:0] ob_in  [3] = '{16'h0000, 16'h8000, 16'hFFFF};
    logic [DW-1:0] ob_out [3] = '{16'h8000, 16'h0000, 16'h7FFF};

    always #5 clk = ~clk;

    fft_frame_loader #(.FRAME_LEN(FL), .DW(DW), .SRC_LAT(SL), .OFFSET_BIN(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_src_req(src_req),
        .i_src_data(src_data), .o_xn_re(xn_re), .o_xn_im(xn_im),
        .o_xn_valid(xn_valid), .o_xn_sof(xn_sof), .o_xn_eof(xn_eof),
        .i_xn_ready(xn_ready), .o_busy(busy), .o_frame_done(frame_done),
        .o_frame_cnt(frame_cnt)
    );

    fft_frame_loader #(.FRAME_LEN(FL), .DW(DW), .SRC_LAT(SL), .OFFSET_BIN(1)) u_ob (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_src_req(b_src_req),
        .i_src_data(src_data), .o_xn_re(b_re), .o_xn_im(b_im),
        .o_xn_valid(b_valid), .o_xn_sof(b_sof), .o_xn_eof(b_eof),
        .i_xn_ready(xn_ready), .o_busy(b_busy), .o_frame_done(b_done),
        .o_frame_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, compare outputs against the
    // model, then advance the model by what happens at the next rising edge.
    task automatic tick(input logic st, input logic rdy, input logic rs);
        logic r;
        logic [DW-1:0] d;
        @(negedge clk);
        start = st; xn_ready = rdy; rst = rs;
        if (chk_en) begin
            chk("xn_valid", 32'(xn_valid), 32'(expq.size() != 0));
            chk("ob_valid", 32'(b_valid), 32'(expq.size() != 0));
            chk("xn_im", 32'(xn_im), 32'd0);
            chk("ob_im", 32'(b_im), 32'd0);
            chk("fifo_overflow", 32'(expq.size() <= DEPTH), 32'd1);
            if (expq.size() != 0) begin
                chk("xn_re", 32'(xn_re), 32'(expq[0]));
                chk("ob_re", 32'(b_re), 32'(expq[0] ^ 16'h8000));
                chk("xn_sof", 32'(xn_sof), 32'(hs_idx == 0));
                chk("xn_eof", 32'(xn_eof), 32'(hs_idx == FL - 1));
                if (tab && hs_cnt < 3) chk("ob_table", 32'(b_re), 32'(ob_out[hs_cnt]));
            end else begin
                chk("sof_empty", 32'(xn_sof), 32'd0);
                chk("eof_empty", 32'(xn_eof), 32'd0);
            end
        end
        if (expq.size() != 0 && rdy) begin
            void'(expq.pop_front());
            hs_idx = (hs_idx + 1) % FL;
            hs_cnt++;
        end
        req_cnt += int'(src_req);
        done_cnt += int'(frame_done);
        rq.push_back(src_req);
        if (rq.size() > SL) begin
            r = rq.pop_front();
            d = DW'($urandom);
            if (r) begin
                d = (mode == 0) ? DW'(addr) : ((tab && addr < 3) ? ob_in[addr] : d);
                addr++;
                expq.push_back(d);
            end
            src_data = d;
        end
        if (rs) begin
            rq.delete(); expq.delete();
            hs_idx = 0; addr = 0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(xn_valid), 32'd0);
        chk({tag, "_req"}, 32'(src_req), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_re"}, 32'(xn_re), 32'd0);
    endtask

    // pat: 0 ready=1, 1 ready 1,0,0,1 repeating, 2 random; spam keeps start
    // high through RUN, DRAIN and DONE.
    task automatic run_frame(input int pat, input bit spam, input int exp_cnt);
        int k;
        bit seen;
        logic rdy;
        hs_cnt = 0; req_cnt = 0; done_cnt = 0; seen = 0; k = 0;
        tick(1'b1, 1'b1, 1'b0);
        chk("busy_at_start", 32'(busy), 32'd0);
        do begin
            rdy = (pat == 0) ? 1'b1 : (pat == 1) ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom);
            tick(spam && !seen, rdy, 1'b0);
            if (frame_done) seen = 1;
            k++;
        end while (busy && k < 6000);
        chk("frame_timeout", 32'(busy), 32'd0);
        chk("hs_per_frame", 32'(hs_cnt), 32'(FL));
        chk("req_per_frame", 32'(req_cnt), 32'(FL));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        chk("idle_req", 32'(src_req), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("frame_cnt_hold", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int k;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk_en = 1;
        tick(1'b0, 1'b0, 1'b0);
        chk_all_zero("reset");

        // Cycle-exact timing with an index-valued source and ready held high.
        repeat (8) tick(1'b0, 1'b1, 1'b0);
        hs_cnt = 0; req_cnt = 0;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 1028; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            chk("t1_src_req", 32'(src_req), 32'(i <= FL));
            chk("t1_valid", 32'(xn_valid), 32'(i >= 3 && i <= FL + 2));
            chk("t1_sof", 32'(xn_sof), 32'(i == 3));
            chk("t1_eof", 32'(xn_eof), 32'(i == FL + 2));
            chk("t1_done", 32'(frame_done), 32'(i == FL + 3));
            chk("t1_busy", 32'(busy), 32'(i <= FL + 3));
        end
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_hs", 32'(hs_cnt), 32'(FL));
        chk("t1_req", 32'(req_cnt), 32'(FL));

        // Random data (offset-binary table first) with stalling ready.
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk_all_zero("rst2");
        mode = 1; tab = 1;
        run_frame(1, 0, 1);
        tab = 0;
        run_frame(2, 0, 2);
        run_frame(2, 1, 3);

        // Reset in the middle of a frame, on handshake index 500.
        hs_cnt = 0; k = 0;
        tick(1'b1, 1'b1, 1'b0);
        while (hs_cnt < 500 && k < 2000) begin
            tick(1'b0, 1'b1, 1'b0);
            k++;
        end
        chk("t5_reach", 32'(hs_cnt), 32'd500);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        chk_all_zero("midrst");
        run_frame(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
